// File: rtl/pulse_stretcher.sv
// Pulse stretcher: every rising edge of pulse_in becomes a HOLD_CYCLES-wide
// high level on stretched_out. Pulses are spaced by GAP_CYCLES and up to PEND_MAX events can wait in a queue.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 63,
  parameter int GAP_CYCLES  = 8,
  parameter int PEND_MAX    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  input  logic       clear,
  output logic       stretched_out,
  output logic       busy,
  output logic [1:0] pending,
  output logic       overflow,
  output logic       done
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [1:0] PEND_LIM  = 2'(PEND_MAX);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;

  state_t     r_state, w_state_next;
  logic [7:0] r_cnt, w_cnt_next;
  logic [1:0] r_pend, w_pend_next;
  logic       r_ovf, w_ovf_next;
  logic       r_done, w_done_next;
  logic       r_prev;
  logic       w_event;

  assign w_event = pulse_in & ~r_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_pend  <= 2'd0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_pend  <= w_pend_next;
      r_ovf   <= w_ovf_next;
      r_done  <= w_done_next;
      r_prev  <= pulse_in;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pend_next  = r_pend;
    w_ovf_next   = r_ovf;
    w_done_next  = 1'b0;
    if (clear) begin
      w_state_next = S_IDLE;
      w_cnt_next   = 8'd0;
      w_pend_next  = 2'd0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            w_state_next = S_HOLD;
            w_cnt_next   = 8'd0;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_next = S_GAP;
            w_cnt_next   = 8'd0;
            w_done_next  = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
          if (w_event) begin
            if (r_pend < PEND_LIM) w_pend_next = r_pend + 2'd1;
            else                   w_ovf_next  = 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_next = 8'd0;
            // A new event here either replaces the dequeued one or starts directly.
            if (r_pend != 2'd0) begin
              w_state_next = S_HOLD;
              w_pend_next  = w_event ? r_pend : r_pend - 2'd1;
            end else if (w_event) begin
              w_state_next = S_HOLD;
            end else begin
              w_state_next = S_IDLE;
            end
          end else begin
            w_cnt_next = r_cnt + 8'd1;
            if (w_event) begin
              if (r_pend < PEND_LIM) w_pend_next = r_pend + 2'd1;
              else                   w_ovf_next  = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = 8'd0;
        end
      endcase
    end
  end

  assign stretched_out = (r_state == S_HOLD);
  assign busy          = (r_state != S_IDLE);
  assign pending       = r_pend;
  assign overflow      = r_ovf;
  assign done          = r_done;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random traffic, compared each
// cycle against a schedule-of-pulse-start-times reference model.
module tb_pulse_stretcher;

  localparam int HOLD = 63;
  localparam int GAP  = 8;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic       clear;
  logic       stretched_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: start cycle of every accepted event, sticky overflow, previous input.
  int   sched[$];
  logic m_ovf  = 1'b0;
  logic m_prev = 1'b0;
  int   cyc    = 0;

  pulse_stretcher #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .PEND_MAX(PMAX)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .clear(clear),
    .stretched_out(stretched_out), .busy(busy), .pending(pending),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int starts_after(int c);
    int n = 0;
    foreach (sched[i]) if (sched[i] > c) n++;
    return n;
  endfunction

  function automatic logic [5:0] model_out(int c);
    logic s = 1'b0;
    logic b = 1'b0;
    logic d = 1'b0;
    int   p;
    foreach (sched[i]) begin
      if (sched[i] <= c && c < sched[i] + HOLD)       s = 1'b1;
      if (sched[i] <= c && c < sched[i] + HOLD + GAP) b = 1'b1;
      if (c == sched[i] + HOLD)                       d = 1'b1;
    end
    p = starts_after(c);
    return {s, b, 2'(p), m_ovf, d};
  endfunction

  // Advance the model across one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    logic ev;
    int   nxt;
    ev = pulse_in & ~m_prev;
    if (!reset) begin
      sched.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b0;
    end else begin
      if (clear) begin
        sched.delete();
        m_ovf = 1'b0;
      end else if (ev) begin
        if (starts_after(cyc + 1) < PMAX) begin
          nxt = cyc + 1;
          if (sched.size() > 0 && sched[$] + HOLD + GAP > nxt) nxt = sched[$] + HOLD + GAP;
          sched.push_back(nxt);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev = pulse_in;
    end
    cyc++;
    while (sched.size() > 0 && sched[0] + HOLD + GAP + 1 < cyc) void'(sched.pop_front());
  endtask

  task automatic check_vec(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed={str,busy,pend,ovf,done}=%b expected=%b",
                tag, cyc, obs, exp);
  endtask

  task automatic cycle(input logic pi, input logic clr, input logic rst);
    @(negedge clk);
    check_vec("cycle", {stretched_out, busy, pending, overflow, done}, model_out(cyc));
    pulse_in = pi;
    clear    = clr;
    reset    = rst;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic four_events();
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
    end
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    clear    = 1'b0;
    #1 reset = 1'b0;
    #1 check_vec("reset_async", {stretched_out, busy, pending, overflow, done}, 6'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    idle_n(3);

    // Single one-cycle event from idle.
    cycle(1'b1, 1'b0, 1'b1);
    idle_n(80);

    // Level held for 200 cycles counts once.
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 1'b1);
    idle_n(10);

    // Four extra events in the first HOLD: queue fills, one dropped.
    four_events();
    idle_n(4 * (HOLD + GAP) + 10);

    // Event exactly on the last GAP cycle with nothing queued.
    cycle(1'b1, 1'b0, 1'b1);
    idle_n(HOLD + GAP - 1);
    cycle(1'b1, 1'b0, 1'b1);
    idle_n(HOLD + GAP + 10);

    // Clear together with an event mid-HOLD while pending=2 and overflow set.
    four_events();
    idle_n(HOLD + GAP + 10);
    cycle(1'b1, 1'b1, 1'b1);
    idle_n(HOLD + GAP + 10);

    // Async reset at cycle 30 of HOLD with events queued.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    idle_n(28);
    @(negedge clk);
    check_vec("pre_reset", {stretched_out, busy, pending, overflow, done}, model_out(cyc));
    #2 reset = 1'b0;
    #1 check_vec("async_rst", {stretched_out, busy, pending, overflow, done}, 6'b0);
    @(posedge clk);
    model_edge();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    // Release with pulse_in already high: one event on the first edge.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1);
    idle_n(HOLD + GAP + 10);

    // Random traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      logic pi, clr;
      pi  = ($urandom_range(0, 24) == 0) || (pulse_in && $urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 399) == 0);
      cycle(pi, clr, 1'b1);
    end
    idle_n(HOLD * 4 + GAP * 4 + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter HOLD_CYCLES, default 63, cycles stretched_out is held high per event (legal range 1..255).
REQ-002 Parameter GAP_CYCLES, default 8, minimum low cycles between consecutive stretched pulses (legal range 1..255).
REQ-003 Parameter PEND_MAX, default 3, maximum queued events awaiting output (legal range 1..3).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted (0) forces the reset state immediately, deassertion is synchronous to clk.
REQ-006 pulse_in  input  1  clean event request, typically a one-cycle debounced pulse; each rising edge is one event.
REQ-007 clear  input  1  synchronous active-high abort.
REQ-008 stretched_out  output  1  stretched level, high for exactly HOLD_CYCLES cycles per event.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 pending  output  2  count of queued events not yet started.
REQ-011 overflow  output  1  sticky flag, event dropped because the queue was full.
REQ-012 done  output  1  one-cycle pulse marking completion of each stretched pulse.

Function
REQ-013 The block SHALL register pulse_in and define event = pulse_in AND NOT previous pulse_in; a level held high SHALL count as one event.
REQ-014 The FSM SHALL have states IDLE, HOLD, GAP, and an internal counter 8 bits wide.
REQ-015 In IDLE with event: next edge enters HOLD, stretched_out=1, counter=0; latency from the event cycle to stretched_out high is exactly 1 clock.
REQ-016 In HOLD: counter increments each cycle; when counter==HOLD_CYCLES-1, next edge enters GAP, counter=0, stretched_out=0, done=1 for that single cycle.
REQ-017 In GAP: stretched_out stays 0; when counter==GAP_CYCLES-1, next edge enters HOLD with pending decremented if pending>0, else IDLE.
REQ-018 Event in HOLD or GAP: pending increments if pending<PEND_MAX; otherwise the event is dropped and overflow is set to 1.
REQ-019 Event in the same cycle as a GAP-to-HOLD pending decrement: pending SHALL be unchanged (net zero) and no overflow is raised.
REQ-020 Event in the same cycle as a GAP-to-IDLE transition SHALL start HOLD directly instead of entering IDLE, pending unchanged.
REQ-021 overflow SHALL remain 1 until reset or clear.
REQ-022 clear=1: next edge forces IDLE, stretched_out=0, counter=0, pending=0, overflow=0, done=0; clear SHALL win over a simultaneous event, which is discarded.
REQ-023 busy SHALL equal 1 in HOLD and GAP and 0 in IDLE, aligned to the state register.
REQ-024 Back-to-back queued events SHALL produce stretched pulses separated by exactly GAP_CYCLES low cycles.

Reset
REQ-025 While reset=0: state=IDLE, stretched_out=0, busy=0, pending=0, overflow=0, done=0, counter=0, registered pulse_in=0, independent of clk.
REQ-026 reset asserted mid-HOLD or mid-GAP SHALL immediately drop stretched_out and discard all queued events.
REQ-027 After reset release, a pulse_in already high SHALL count as one event on the first clock edge.

Verification (defaults HOLD_CYCLES=63, GAP_CYCLES=8, PEND_MAX=3)
REQ-028 Single one-cycle pulse_in in IDLE -> stretched_out high exactly 63 cycles starting 1 cycle later, done high 1 cycle after fall, busy low 8 cycles after that.
REQ-029 pulse_in held high 200 cycles -> exactly one 63-cycle pulse, pending stays 0.
REQ-030 Four events during the first HOLD -> pending reaches 3, overflow=1, then 4 pulses total of 63 high and 8 low each, pending counting 3,2,1,0.
REQ-031 Event on the last GAP cycle with pending=0 -> HOLD re-entered with no IDLE cycle, busy stays 1.
REQ-032 clear and event in the same cycle mid-HOLD with pending=2 and overflow=1 -> next cycle IDLE, all outputs 0, no new pulse.
REQ-033 reset pulled low at cycle 30 of HOLD -> stretched_out=0 asynchronously before the next edge, pending=0 after release.
